ntt_intt_controller: RTL and testbench

//  Sequences one ntt_intt_pu instance for a single transform. Accepts one coefficient vector and a

---
 rtl/ntt_intt_controller.sv | 97 +++++++++
 tb/tb_ntt_intt_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_intt_controller.sv
// Sequencer for a single ntt_intt_pu: accepts a vector, runs LAT butterfly stages, returns the result.
// Optional NTT_CTRL_PERF_CNT_EN adds saturating xfer_count / busy_cycles performance counters.
module ntt_intt_controller #(
    parameter int N   = 17,
    parameter int D   = 16,
    parameter int LAT = $clog2(D)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_inv,
    input  logic [D*N-1:0] in_data,
    output logic           pu_rst,
    output logic           pu_inv,
    output logic [D*N-1:0] pu_a,
    input  logic [D*N-1:0] pu_an,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D*N-1:0] out_data,
    output logic           out_inv
`ifdef NTT_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]    xfer_count,
    output logic [31:0]    busy_cycles
`endif
);

    localparam int CW = $clog2(LAT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_stage;
    logic            w_accept;
    logic            w_last;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
    assign out_valid = (r_state == S_HOLD);
    assign pu_rst    = (r_state != S_RUN);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == S_RUN) && (r_stage == CW'(LAT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LOAD;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = in_valid ? S_LOAD : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pu_a     <= '0;
            pu_inv   <= 1'b0;
            out_data <= '0;
            out_inv  <= 1'b0;
            r_stage  <= '0;
        end else begin
            // Operands only move at accept, so the PU sees them stable through LOAD and RUN.
            if (w_accept) begin
                pu_a   <= in_data;
                pu_inv <= in_inv;
            end
            if (r_state == S_LOAD)      r_stage <= '0;
            else if (r_state == S_RUN)  r_stage <= r_stage + 1'b1;
            if (w_last) begin
                out_data <= pu_an;
                out_inv  <= pu_inv;
            end
        end
    end

`ifdef NTT_CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count  <= '0;
            busy_cycles <= '0;
        end else begin
            if (out_valid && out_ready && (xfer_count != '1))
                xfer_count <= xfer_count + 32'd1;
            if (((r_state == S_LOAD) || (r_state == S_RUN)) && (busy_cycles != '1))
                busy_cycles <= busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ntt_intt_controller.sv
// Bench for ntt_intt_controller: a latency-accurate PU model computes a direct-form NTT mod 65537.
// Performance counters are checked when NTT_CTRL_PERF_CNT_EN is defined.
module tb_ntt_intt_controller;

    localparam int N   = 17;
    localparam int D   = 16;
    localparam int LAT = $clog2(D);
    localparam int W   = D * N;
    localparam longint unsigned Q = 65537;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_inv = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         pu_rst;
    logic         pu_inv;
    logic [W-1:0] pu_a;
    logic [W-1:0] pu_an;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_inv;
`ifdef NTT_CTRL_PERF_CNT_EN
    logic [31:0]  xfer_count;
    logic [31:0]  busy_cycles;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int xfers    = 0;
    int mc       = 0;

    ntt_intt_controller #(.N(N), .D(D), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data),
        .pu_rst(pu_rst), .pu_inv(pu_inv), .pu_a(pu_a), .pu_an(pu_an),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv)
`ifdef NTT_CTRL_PERF_CNT_EN
        , .xfer_count(xfer_count), .busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic longint unsigned modpow(input longint unsigned b, input longint unsigned e);
        longint unsigned r = 1;
        longint unsigned x = b % Q;
        for (int i = 0; i < 20; i++) begin
            if (e[i]) r = (r * x) % Q;
            x = (x * x) % Q;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] ntt_ref(input logic [W-1:0] v, input logic inv);
        logic [W-1:0]    r;
        longint unsigned tw[D];
        longint unsigned w, acc, a;
        r = '0;
        w = modpow(3, (Q - 1) / D);
        if (inv) w = modpow(w, D - 1);
        tw[0] = 1;
        for (int i = 1; i < D; i++) tw[i] = (tw[i-1] * w) % Q;
        for (int k = 0; k < D; k++) begin
            acc = 0;
            for (int j = 0; j < D; j++) begin
                a   = longint'(v[j*N +: N]);
                acc = (acc + a * tw[(j * k) % D]) % Q;
            end
            if (inv) acc = (acc * modpow(D, Q - 2)) % Q;
            r[k*N +: N] = acc[N-1:0];
        end
        return r;
    endfunction

    // PU model: result is only valid after LAT-1 running edges, so capture must be exact.
    always @(posedge clk) begin
        if (pu_rst) mc <= 0;
        else        mc <= mc + 1;
    end
    always_comb pu_an = (mc == LAT - 1) ? ntt_ref(pu_a, pu_inv) : ~ntt_ref(pu_a, pu_inv);

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[i*N +: N] = N'($urandom_range(0, 65536));
        return v;
    endfunction

    task automatic transform(input logic [W-1:0] vec, input logic inv, input int stall,
                             input logic [W-1:0] exp);
        in_data   = vec;
        in_inv    = inv;
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        #1;
        chk("accept_ready", W'(in_ready), W'(1'b1));
        step;
        in_valid = 1'b0;
        in_data  = ~vec;
        in_inv   = ~inv;
        for (int n = 1; n <= LAT + 2; n++) begin
            if (n > 1) step;
            chk("out_valid_timing", W'(out_valid), W'(n == LAT + 2));
            chk("pu_rst_timing", W'(pu_rst), W'(!(n >= 2 && n <= LAT + 1)));
            chk("pu_a_hold", pu_a, vec);
            chk("pu_inv_hold", W'(pu_inv), W'(inv));
        end
        chk("out_data", out_data, exp);
        chk("out_inv", W'(out_inv), W'(inv));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rand_vec();
            in_inv   = 1'($urandom_range(0, 1));
            #1;
            chk("stall_in_ready", W'(in_ready), W'(1'b0));
            step;
            chk("stall_out_valid", W'(out_valid), W'(1'b1));
            chk("stall_out_data", out_data, exp);
            chk("stall_out_inv", W'(out_inv), W'(inv));
            chk("stall_pu_a", pu_a, vec);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", W'(in_ready), W'(1'b1));
        step;
        xfers++;
        chk("after_hs_out_valid", W'(out_valid), W'(1'b0));
        chk("after_hs_in_ready", W'(in_ready), W'(1'b1));
    endtask

    initial begin
        logic [W-1:0] v, e, ramp;
        logic         iv;
        logic [W-1:0] vb[3];
        logic         ib[3];
        logic [W-1:0] expq[$];
        logic         invq[$];
        int           accq[$];
        int           cyc, idx, got, last_acc, ac;
        logic         acc;

        // Reset state
        step;
        step;
        chk("rst_in_ready", W'(in_ready), W'(1'b1));
        chk("rst_out_valid", W'(out_valid), W'(1'b0));
        chk("rst_pu_rst", W'(pu_rst), W'(1'b1));
        chk("rst_pu_a", pu_a, '0);
        chk("rst_pu_inv", W'(pu_inv), W'(1'b0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_inv", W'(out_inv), W'(1'b0));
        rst = 1'b0;
        step;

        // Asynchronous reset in the middle of RUN
        in_data  = rand_vec();
        in_inv   = 1'b1;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        step;
        chk("midrun_pu_rst_low", W'(pu_rst), W'(1'b0));
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", W'(in_ready), W'(1'b1));
        chk("midrst_out_valid", W'(out_valid), W'(1'b0));
        chk("midrst_pu_rst", W'(pu_rst), W'(1'b1));
        chk("midrst_pu_a", pu_a, '0);
        chk("midrst_pu_inv", W'(pu_inv), W'(1'b0));
        step;
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            step;
            chk("midrst_no_pulse", W'(out_valid), W'(1'b0));
        end
`ifdef NTT_CTRL_PERF_CNT_EN
        chk("perf_rst_xfer", W'(xfer_count), '0);
        chk("perf_rst_busy", W'(busy_cycles), '0);
`endif

        // Forward transform of 0..15, then inverse round trip
        for (int i = 0; i < D; i++) ramp[i*N +: N] = N'(i);
        e = ntt_ref(ramp, 1'b0);
        transform(ramp, 1'b0, 0, e);
        transform(e, 1'b1, 0, ramp);

        // Stalled output with ignored input pulses
        v  = rand_vec();
        iv = 1'($urandom_range(0, 1));
        transform(v, iv, 10, ntt_ref(v, iv));

        // Back-to-back stream with in_valid held high
        for (int i = 0; i < 3; i++) begin
            vb[i] = rand_vec();
            ib[i] = 1'($urandom_range(0, 1));
        end
        idx       = 0;
        got       = 0;
        cyc       = 0;
        last_acc  = -1;
        in_data   = vb[0];
        in_inv    = ib[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        for (int t = 0; t < 40 && got < 3; t++) begin
            acc = in_valid && in_ready;
            step;
            cyc++;
            if (acc) begin
                if (last_acc >= 0) chk("b2b_accept_spacing", W'(cyc - last_acc), W'(LAT + 2));
                last_acc = cyc;
                accq.push_back(cyc);
                expq.push_back(ntt_ref(vb[idx], ib[idx]));
                invq.push_back(ib[idx]);
                idx++;
                if (idx < 3) begin
                    in_data = vb[idx];
                    in_inv  = ib[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("b2b_unexpected_result", W'(1'b1), W'(1'b0));
                end else begin
                    ac = accq.pop_front();
                    chk("b2b_latency", W'(cyc - ac), W'(LAT + 1));
                    chk("b2b_out_data", out_data, expq.pop_front());
                    chk("b2b_out_inv", W'(out_inv), W'(invq.pop_front()));
                end
                got++;
                xfers++;
            end
        end
        chk("b2b_result_count", W'(got), W'(3));
        step;
        chk("b2b_idle_after", W'(out_valid), W'(1'b0));

        // Extra randomized transforms with random stalls
        for (int t = 0; t < 3; t++) begin
            v  = rand_vec();
            iv = 1'($urandom_range(0, 1));
            transform(v, iv, int'($urandom_range(0, 3)), ntt_ref(v, iv));
        end

`ifdef NTT_CTRL_PERF_CNT_EN
        chk("perf_xfer_count", W'(xfer_count), W'(xfers));
        chk("perf_busy_cycles", W'(busy_cycles), W'((LAT + 1) * xfers));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
